// File: rtl/riscv_pert_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pert_cfg_master
// Description : Debug-bus master for the perturbation unit's debug port.
//               Buffers read/write configuration commands in a small FIFO
//               and issues them one at a time as req/gnt/rvalid transactions,
//               returning read data or a timeout error. Perturbation
//               registers (addr[13:8]==6'b000110, index addr[5:2]) and all
//               other addresses are forwarded unmodified.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_pert_cfg_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [14:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        dbg_req_o,
  output logic        dbg_we_o,
  output logic [14:0] dbg_addr_o,
  output logic [31:0] dbg_wdata_o,
  input  logic        dbg_gnt_i,
  input  logic        dbg_rvalid_i,
  input  logic [31:0] dbg_rdata_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [PTR_W:0]   C_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  cmd_t             fifo_q [FIFO_DEPTH];
  cmd_t             fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             dbg_req_q, dbg_req_d;
  logic             dbg_we_q, dbg_we_d;
  logic [14:0]      dbg_addr_q, dbg_addr_d;
  logic [31:0]      dbg_wdata_q, dbg_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_we_q, rsp_we_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  logic             push;
  logic             pop;
  cmd_t             head;
  logic [CNT_W-1:0] tmo_inc;
  logic             tmo_hit;

  // Pop is decided purely from registered state so ready can be precomputed.
  assign push    = cmd_valid_i & cmd_ready_q;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign head    = fifo_q[rd_ptr_q];
  // Saturating increment; the hit fires on the edge the counter would reach the limit.
  assign tmo_inc = (tmo_cnt_q == C_TMO) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_inc == C_TMO);

  // FIFO storage, pointers, occupancy and the precomputed ready flag.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    // A full FIFO still accepts a push in any cycle where the FSM will pop.
    cmd_ready_d = !((count_d == C_FULL) && (state_d != S_IDLE));
  end

  // Transaction FSM: launch from IDLE, hold request until grant, await rvalid.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    dbg_req_d   = dbg_req_q;
    dbg_we_d    = dbg_we_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          dbg_req_d   = 1'b1;
          dbg_we_d    = head.we;
          dbg_addr_d  = head.addr;
          dbg_wdata_d = head.wdata;
          tmo_cnt_d   = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        tmo_cnt_d = tmo_inc;
        if (dbg_gnt_i) begin
          dbg_req_d = 1'b0;
          state_d   = S_WAIT;
        end else if (tmo_hit) begin
          dbg_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = dbg_we_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end
      end
      S_WAIT: begin
        tmo_cnt_d = tmo_inc;
        if (dbg_rvalid_i) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = dbg_we_q;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = dbg_we_q ? 32'h0 : dbg_rdata_i;
          state_d     = S_IDLE;
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = dbg_we_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        dbg_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Command storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  // Control and output registers; reset discards any queued commands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      state_q     <= S_IDLE;
      tmo_cnt_q   <= '0;
      dbg_req_q   <= 1'b0;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dbg_req_q   <= dbg_req_d;
      dbg_we_q    <= dbg_we_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = (count_q != '0) || (state_q != S_IDLE);
  assign dbg_req_o   = dbg_req_q;
  assign dbg_we_o    = dbg_we_q;
  assign dbg_addr_o  = dbg_addr_q;
  assign dbg_wdata_o = dbg_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_pert_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_pert_cfg_master
// Description : Scoreboard bench for riscv_pert_cfg_master with a small
//               debug-target model (configurable grant delay / drops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_pert_cfg_master;

  localparam int C_DEPTH = 4;
  localparam int C_TMO   = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [14:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o, rsp_we_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        busy_o;
  logic        dbg_req_o, dbg_we_o;
  logic [14:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic        dbg_gnt_i;
  logic        dbg_rvalid_i;
  logic [31:0] dbg_rdata_i;

  riscv_pert_cfg_master #(.FIFO_DEPTH(C_DEPTH), .TIMEOUT_CYCLES(C_TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
    .dbg_req_o(dbg_req_o), .dbg_we_o(dbg_we_o), .dbg_addr_o(dbg_addr_o),
    .dbg_wdata_o(dbg_wdata_o), .dbg_gnt_i(dbg_gnt_i),
    .dbg_rvalid_i(dbg_rvalid_i), .dbg_rdata_i(dbg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: after rising edge k it holds k.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          cyc;   // -1 means the arrival cycle is not checked
  } exp_t;
  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // ---------------- target model ----------------
  logic        hold_low  = 1'b0;
  int          gnt_delay = 0;
  logic        drop_rsp  = 1'b0;
  int          stale_req = 0;
  int          req_cycles = 0;
  logic [31:0] tmem [16];

  assign dbg_gnt_i = dbg_req_o && !hold_low && (req_cycles >= gnt_delay);

  initial begin : target
    logic        g, r, we;
    logic [14:0] a;
    logic [31:0] wd;
    int          stale_done;
    stale_done   = 0;
    dbg_rvalid_i = 1'b0;
    dbg_rdata_i  = '0;
    foreach (tmem[i]) tmem[i] = '0;
    forever begin
      @(negedge clk_i);
      r = dbg_req_o; g = dbg_req_o && dbg_gnt_i;
      we = dbg_we_o; a = dbg_addr_o; wd = dbg_wdata_o;
      @(posedge clk_i); #1;
      if (r && !g) req_cycles++; else req_cycles = 0;
      dbg_rvalid_i = 1'b0;
      dbg_rdata_i  = '0;
      if (stale_req != stale_done) begin
        stale_done++;
        dbg_rvalid_i = 1'b1;
        dbg_rdata_i  = 32'hDEAD_BEEF;
      end else if (g && !drop_rsp) begin
        dbg_rvalid_i = 1'b1;
        if (a[13:8] == 6'b000110) begin
          if (we) tmem[a[5:2]] = wd;
          else    dbg_rdata_i = tmem[a[5:2]];
        end else begin
          dbg_rdata_i = we ? 32'h0 : (32'hC0DE_0000 | {17'h0, a});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && rsp_valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 required no response (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_we", {31'h0, rsp_we_o}, {31'h0, e.we});
          check("rsp_err", {31'h0, rsp_err_o}, {31'h0, e.err});
          check("rsp_rdata", rsp_rdata_o, e.rdata);
          if (e.cyc >= 0) check("rsp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic we, input logic [14:0] a, input logic [31:0] d, output int pcyc);
    logic rdy;
    int   guard;
    guard = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_wdata_i = d;
    forever begin
      rdy = cmd_ready_o;
      @(posedge clk_i); #1;
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        n_chk++;
        $display("FAIL push_ready_timeout: got cmd_ready_o=0 for 50 cycles required 1");
        break;
      end
    end
    cmd_valid_i = 1'b0;
    pcyc = cyc;
  endtask

  task automatic expect_rsp(input logic we, input logic err, input logic [31:0] rd, input int c);
    exp_t e;
    e.we = we; e.err = err; e.rdata = rd; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || sb.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_in_budget", {31'h0, (n < 200)}, 32'h1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int p, p2, nreq, nstable;

    // Reset state
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_dbg_req", {31'h0, dbg_req_o}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;

    // Write 1 to pert reg 4, combinational grant, rvalid one cycle later
    push(1'b1, 15'h0610, 32'h0000_0001, p);
    expect_rsp(1'b1, 1'b0, 32'h0, p + 3);
    nreq = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (dbg_req_o) nreq++;
    end
    check("wr_req_len", nreq, 1);
    check("rsp_valid_pulse", {31'h0, rsp_valid_o}, 32'h0);
    check("rsp_we_held", {31'h0, rsp_we_o}, 32'h1);
    wait_idle();

    // Read back reg 4, then a queued write: second request launches at +4
    push(1'b0, 15'h0610, 32'h0, p);
    expect_rsp(1'b0, 1'b0, 32'h0000_0001, p + 3);
    push(1'b1, 15'h0614, 32'h0000_1234, p2);
    expect_rsp(1'b1, 1'b0, 32'h0, p + 6);
    wait_idle();

    // Five back-to-back pushes with grant held low
    hold_low = 1'b1;
    push(1'b1, 15'h0600, 32'h10, p);  expect_rsp(1'b1, 1'b0, 32'h0, -1);
    push(1'b1, 15'h0604, 32'h11, p);  expect_rsp(1'b1, 1'b0, 32'h0, -1);
    push(1'b1, 15'h0608, 32'h12, p);  expect_rsp(1'b1, 1'b0, 32'h0, -1);
    push(1'b1, 15'h060C, 32'h13, p);  expect_rsp(1'b1, 1'b0, 32'h0, -1);
    check("ready_after_4", {31'h0, cmd_ready_o}, 32'h1);
    push(1'b0, 15'h0604, 32'h0, p);   expect_rsp(1'b0, 1'b0, 32'h11, -1);
    check("ready_full", {31'h0, cmd_ready_o}, 32'h0);
    check("busy_full", {31'h0, busy_o}, 32'h1);
    hold_low = 1'b0;
    wait_idle();

    // Pass-through read, grant delayed three cycles
    gnt_delay = 3;
    push(1'b0, 15'h0004, 32'h5555_AAAA, p);
    expect_rsp(1'b0, 1'b0, 32'hC0DE_0004, p + 6);
    nreq = 0; nstable = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (dbg_req_o) nreq++;
      if (dbg_req_o && !dbg_we_o && dbg_addr_o == 15'h0004 && dbg_wdata_o == 32'h5555_AAAA)
        nstable++;
    end
    check("pt_req_len", nreq, 4);
    check("pt_fields_stable", nstable, 4);
    gnt_delay = 0;
    wait_idle();

    // Timeout with grant never given, then a stale rvalid and a normal read
    hold_low = 1'b1;
    push(1'b1, 15'h0608, 32'h0000_AAAA, p);
    expect_rsp(1'b1, 1'b1, 32'h0, p + 1 + C_TMO);
    repeat (C_TMO + 1) @(negedge clk_i);
    check("tmo_req_before", {31'h0, dbg_req_o}, 32'h1);
    @(negedge clk_i);
    check("tmo_req_after", {31'h0, dbg_req_o}, 32'h0);
    stale_req++;
    repeat (4) @(negedge clk_i);
    check("stale_busy", {31'h0, busy_o}, 32'h0);
    hold_low = 1'b0;
    @(posedge clk_i); #1;
    push(1'b0, 15'h0608, 32'h0, p);
    expect_rsp(1'b0, 1'b0, 32'h12, p + 3);
    wait_idle();

    // Reset while in WAIT with two commands queued
    drop_rsp = 1'b1;
    push(1'b1, 15'h0620, 32'hA, p);
    push(1'b1, 15'h0624, 32'hB, p);
    push(1'b1, 15'h0628, 32'hC, p);
    check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
    check("pre_rst_req", {31'h0, dbg_req_o}, 32'h0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, dbg_req_o}, 32'h0);
    check("mid_rst_busy", {31'h0, busy_o}, 32'h0);
    check("mid_rst_ready", {31'h0, cmd_ready_o}, 32'h1);
    drop_rsp = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    check("post_rst_busy", {31'h0, busy_o}, 32'h0);

    // Normal operation after reset
    @(posedge clk_i); #1;
    push(1'b0, 15'h0604, 32'h0, p);
    expect_rsp(1'b0, 1'b0, 32'h11, p + 3);
    wait_idle();

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
